zbuf_depth_test: RTL

ZBUF_DEPTH_TEST -- requirements
Module: zbuf_depth_test

---
 rtl/zbuf_depth_test.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/zbuf_depth_test.sv
// zbuf_depth_test: per-fragment depth test against an on-chip z-buffer, with a full-buffer clear engine.
// Define ZBUF_STATS_EN to add the stat_pass / stat_fail / stat_clip counters and ports.
//
// state | meaning
// IDLE  | waiting for a fragment or a clear request
// READ  | depth RAM read of the fragment's address in flight
// TEST  | compare fragment z against stored depth
// WRITE | store new depth, emit pixel
// CLEAR | sweep 0x7FFF into every depth word
module zbuf_depth_test #(
    parameter int SCREEN_W = 64,
    parameter int SCREEN_H = 64,
    parameter int ADDR_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frag_valid,
    output logic               frag_ready,
    input  logic signed [15:0] frag_x,
    input  logic signed [15:0] frag_y,
    input  logic signed [15:0] frag_z,
    input  logic [15:0]        frag_red,
    input  logic [15:0]        frag_green,
    input  logic [15:0]        frag_blue,
    input  logic               clear_start,
    output logic               busy,
    output logic               pix_valid,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic [23:0]        pix_rgb
`ifdef ZBUF_STATS_EN
    ,
    output logic [31:0]        stat_pass,
    output logic [31:0]        stat_fail,
    output logic [31:0]        stat_clip
`endif
);

    localparam int NPIX = SCREEN_W * SCREEN_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic signed [15:0] Z_FAR = 16'sh7FFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        TEST  = 3'd2,
        WRITE = 3'd3,
        CLEAR = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic                accept;
    logic                in_range;
    logic [31:0]         addr_full;
    logic [ADDR_W-1:0]   frag_addr;
    logic [ADDR_W-1:0]   addr_q;
    logic signed [15:0]  z_q;
    logic [23:0]         rgb_q;
    logic [ADDR_W-1:0]   clr_cnt;
    logic                clear_pend;
    logic signed [15:0]  rd_data;
    logic                ram_re;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic signed [15:0]  ram_wdata;
    logic                depth_pass;
    logic                pix_load;
    logic                lsb_unused;

    logic signed [15:0]  depth_mem [NPIX];

    // Only the top byte of each colour channel reaches the framebuffer.
    assign lsb_unused = ^{frag_red[7:0], frag_green[7:0], frag_blue[7:0], addr_full};

    always_comb begin
        in_range  = !frag_x[15] && !frag_y[15]
                    && (32'(frag_x) < SCREEN_W) && (32'(frag_y) < SCREEN_H);
        addr_full = 32'(frag_y) * 32'(SCREEN_W) + 32'(frag_x);
        frag_addr = addr_full[ADDR_W-1:0];
    end

    assign accept     = frag_valid && frag_ready;
    assign depth_pass = z_q < rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (clear_pend) begin
                    state_nxt = CLEAR;
                end else if (accept) begin
                    state_nxt = in_range ? READ : IDLE;
                end else if (clear_start) begin
                    state_nxt = CLEAR;
                end
            end
            READ:    state_nxt = TEST;
            TEST:    state_nxt = depth_pass ? WRITE : IDLE;
            WRITE:   state_nxt = IDLE;
            CLEAR:   state_nxt = (clr_cnt == LAST_ADDR) ? IDLE : CLEAR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frag_ready = 1'b0;
        busy       = 1'b1;
        ram_re     = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = addr_q;
        ram_wdata  = z_q;
        pix_load   = 1'b0;
        unique case (state)
            IDLE: begin
                frag_ready = !clear_pend;
                busy       = 1'b0;
            end
            READ:  ram_re = 1'b1;
            TEST:  ;
            WRITE: begin
                ram_we   = !rst;
                pix_load = 1'b1;
            end
            CLEAR: begin
                // Gated by rst so an aborted sweep leaves the current word untouched.
                ram_we    = !rst;
                ram_waddr = clr_cnt;
                ram_wdata = Z_FAR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            depth_mem[ram_waddr] <= ram_wdata;
        end
        if (ram_re) begin
            rd_data <= depth_mem[addr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= frag_addr;
            z_q    <= frag_z;
            rgb_q  <= {frag_red[15:8], frag_green[15:8], frag_blue[15:8]};
        end
    end

    // A clear arriving while a fragment is in flight waits until the pipeline drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            clear_pend <= 1'b0;
        end else if (state == IDLE && clear_pend) begin
            clear_pend <= 1'b0;
        end else if (clear_start
                     && (state == READ || state == TEST || state == WRITE || accept)) begin
            clear_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end else begin
            clr_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_addr  <= '0;
            pix_rgb   <= '0;
        end else begin
            pix_valid <= pix_load;
            if (pix_load) begin
                pix_addr <= addr_q;
                pix_rgb  <= rgb_q;
            end
        end
    end

`ifdef ZBUF_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pass <= '0;
            stat_fail <= '0;
            stat_clip <= '0;
        end else begin
            if (state == TEST && depth_pass) begin
                stat_pass <= stat_pass + 32'd1;
            end
            if (state == TEST && !depth_pass) begin
                stat_fail <= stat_fail + 32'd1;
            end
            if (accept && !in_range) begin
                stat_clip <= stat_clip + 32'd1;
            end
        end
    end
`endif

endmodule
